// File: rtl/fc_pkg.sv
// Shared types and helpers for the FC-layer input buffer sequencer.
// Holds the controller state encoding, buffer address width and sizing math.
package fc_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        READ,
        DONE
    } state_t;

    localparam int ADDR_W = 6;

    function automatic int ceil_div(input int a, input int b);
        return (a + b - 1) / b;
    endfunction

    function automatic int cnt_w(input int m);
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/fclayer_buffer_ctrl_if.sv
// Write-side stream and read-side buffer controls of the FC input buffer.
// The controller takes the slave view; its environment takes the master view.
interface fclayer_buffer_ctrl_if
    import fc_pkg::*;
#(
    parameter int PE_Num = 8
);

    logic                  din_valid;
    logic                  din_ready;
    logic [2*PE_Num-1:0]   wdata_st;
    logic [ADDR_W-1:0]     buffer_waddr;
    logic                  rd_ready;
    logic                  rdata_st;
    logic [ADDR_W-1:0]     buffer_raddr;
    logic                  dout_valid;
    logic                  dout_last;

    modport master (
        output din_valid, rd_ready,
        input  din_ready, wdata_st, buffer_waddr,
        input  rdata_st, buffer_raddr, dout_valid, dout_last
    );

    modport slave (
        input  din_valid, rd_ready,
        output din_ready, wdata_st, buffer_waddr,
        output rdata_st, buffer_raddr, dout_valid, dout_last
    );

endinterface

// File: rtl/fc_wrap_counter.sv
// Modulo-MOD counter with enable, synchronous clear and a wrap pulse.
// o_wrap is combinational: high when enabled while sitting at MOD-1.
module fc_wrap_counter #(
    parameter int MOD = 2,
    parameter int W   = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_clr,
    input  logic         i_en,
    output logic [W-1:0] o_cnt,
    output logic         o_wrap
);

    logic [W-1:0] r_cnt;
    logic         w_top;

    assign w_top  = (r_cnt == W'(MOD - 1));
    assign o_wrap = i_en & w_top;
    assign o_cnt  = r_cnt;

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= w_top ? '0 : r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/fclayer_buffer_ctrl.sv
// FC-layer input buffer sequencer: bank-interleaved fill from the pooling
// stream, then PASS_NUM replays of DEPTH words to the PE array.
module fclayer_buffer_ctrl
    import fc_pkg::*;
#(
    parameter int dwidth   = 16,
    parameter int PE_Num   = 8,
    parameter int FEAT_NUM = 400,
    parameter int PASS_NUM = 15
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   layer_start,
    output logic                   layer_done,
    fclayer_buffer_ctrl_if.slave   bus
);

    localparam int NB        = 2 * PE_Num;
    localparam int DEPTH     = ceil_div(FEAT_NUM, NB);
    localparam int BW        = cnt_w(NB);
    localparam int PW        = cnt_w(PASS_NUM);
    localparam int LAST_BANK = (FEAT_NUM - 1) % NB;
    localparam int LAST_WORD = (FEAT_NUM - 1) / NB;
    // An illegal configuration simply never leaves IDLE.
    localparam bit PARAM_OK  = (dwidth > 0) && (PASS_NUM >= 1) &&
                               (FEAT_NUM >= 1) && (FEAT_NUM <= 64 * NB);

    state_t              r_state;
    state_t              w_next;
    logic [ADDR_W-1:0]   r_word_cnt;
    logic                r_dout_valid;
    logic                r_dout_last;

    logic [BW-1:0]       w_bank;
    logic                w_bank_wrap;
    logic [ADDR_W-1:0]   w_raddr;
    logic                w_raddr_wrap;
    logic [PW-1:0]       w_pass;
    logic                w_pass_wrap;
    logic                w_accept;
    logic                w_last_wr;
    logic                w_rd;
    logic [NB-1:0]       w_wdata_st;

    assign w_accept  = (r_state == FILL) & bus.din_valid;
    assign w_last_wr = w_accept &
                       (w_bank == BW'(LAST_BANK)) &
                       (r_word_cnt == ADDR_W'(LAST_WORD));
    assign w_rd      = (r_state == READ) & bus.rd_ready;

    fc_wrap_counter #(.MOD(NB), .W(BW)) u_bank_cnt (
        .clk    (clk),
        .rst    (rst),
        .i_clr  (r_state != FILL),
        .i_en   (w_accept),
        .o_cnt  (w_bank),
        .o_wrap (w_bank_wrap)
    );

    fc_wrap_counter #(.MOD(DEPTH), .W(ADDR_W)) u_raddr_cnt (
        .clk    (clk),
        .rst    (rst),
        .i_clr  (r_state != READ),
        .i_en   (w_rd),
        .o_cnt  (w_raddr),
        .o_wrap (w_raddr_wrap)
    );

    fc_wrap_counter #(.MOD(PASS_NUM), .W(PW)) u_pass_cnt (
        .clk    (clk),
        .rst    (rst),
        .i_clr  (r_state != READ),
        .i_en   (w_raddr_wrap),
        .o_cnt  (w_pass),
        .o_wrap (w_pass_wrap)
    );

    always_ff @(posedge clk) begin
        if (rst || r_state != FILL) begin
            r_word_cnt <= '0;
        end else if (w_bank_wrap) begin
            r_word_cnt <= r_word_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE: if (layer_start && PARAM_OK) w_next = FILL;
            FILL: if (w_last_wr) w_next = READ;
            READ: if (w_pass_wrap) w_next = DONE;
            DONE: w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        w_wdata_st = '0;
        if (w_accept) begin
            w_wdata_st[w_bank] = 1'b1;
        end
    end

    // Read latency of the buffer is one cycle; track it here.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_dout_valid <= 1'b0;
            r_dout_last  <= 1'b0;
        end else begin
            r_dout_valid <= w_rd;
            r_dout_last  <= w_rd & (w_raddr == ADDR_W'(DEPTH - 1));
        end
    end

    assign bus.din_ready    = (r_state == FILL);
    assign bus.wdata_st     = w_wdata_st;
    assign bus.buffer_waddr = r_word_cnt;
    assign bus.rdata_st     = w_rd;
    assign bus.buffer_raddr = w_raddr;
    assign bus.dout_valid   = r_dout_valid;
    assign bus.dout_last    = r_dout_last;
    assign layer_done       = (r_state == DONE);

    logic w_unused;
    assign w_unused = ^w_pass;

endmodule

// File: doc/fclayer_buffer_ctrl.md
# fclayer_buffer_ctrl

Sequencer for the fully-connected layer input buffer, which has 2*PE_Num banks, each dwidth wide and 64 words deep. It drives the buffer's per-bank write strobes, write address, read enable and read address. Features arrive from the pooling stage over a valid/ready stream and are written bank-interleaved. The filled buffer is then replayed PASS_NUM times to the FC PE array, once per group of PE_Num output neurons, and the block flags layer completion at the end.

## Interface
- dwidth, 16: feature word width; this block passes no data and uses dwidth only for documentation consistency.
- PE_Num, 8: PE count; there are 2*PE_Num banks.
- FEAT_NUM, 400: features per layer; legal range 1..64*2*PE_Num.
- PASS_NUM, 15: number of full-buffer replays per layer; must be ≥1.
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- layer_start  in  1  pulse; starts a layer; sampled only in IDLE.
- din_valid  in  1  pooling stage presents a feature on the buffer din port.
- din_ready  out  1  controller accepts the feature this cycle.
- wdata_st  out  2*PE_Num  one-hot per-bank write strobe.
- buffer_waddr  out  6  buffer write address.
- rd_ready  in  1  PE array can take one buffer word this cycle.
- rdata_st  out  1  buffer read enable.
- buffer_raddr  out  6  buffer read address.
- dout_valid  out  1  buffer dout holds valid data this cycle.
- dout_last  out  1  qualifies dout_valid; marks the last word of a pass.
- layer_done  out  1  one-cycle pulse after the final read of the final pass.

## Operation
- DEPTH = ceil(FEAT_NUM / (2*PE_Num)) is a constant; with default parameters it is 25.
- States and transitions:
  - IDLE → FILL on layer_start.
  - FILL → READ on acceptance of feature FEAT_NUM-1.
  - READ → DONE on issuing the read at raddr DEPTH-1 in pass PASS_NUM-1.
  - DONE → IDLE unconditionally.
- FILL behaviour:
  - din_ready = 1.
  - On each accept (din_valid & din_ready), wdata_st = one-hot(bank_cnt), otherwise 0.
  - buffer_waddr = word_cnt.
  - bank_cnt increments 0..2*PE_Num-1 and wraps. word_cnt increments on each wrap.
  - Feature k goes to bank k mod 2*PE_Num at address k div 2*PE_Num.
  - Bank i occupies the i-th dwidth slice counted from the MSB of the buffer dout, so feature 0 is the most-significant slice.
- Partial last word: when FEAT_NUM is not a multiple of 2*PE_Num, banks beyond the last feature hold stale data at address DEPTH-1. The PE array masks them; the controller does not clear them.
- READ behaviour:
  - rdata_st = rd_ready.
  - buffer_raddr = raddr_cnt.
  - Each issued read advances raddr_cnt through 0..DEPTH-1 and wraps.
  - On each wrap, pass_cnt increments through 0..PASS_NUM-1.
- DONE behaviour: layer_done = 1 for exactly one cycle.
- In every state except FILL, din_ready = 0, and din_valid is ignored with no write.
- layer_start outside IDLE is ignored, including when it coincides with the DONE cycle.
- Reset, including mid-FILL or mid-READ:
  - Next state is IDLE and all counters are 0.
  - Outputs on the cycle after rst: din_ready = 0, wdata_st = 0, rdata_st = 0, dout_valid = 0, dout_last = 0, layer_done = 0, buffer_waddr = 0, buffer_raddr = 0.
  - A read in flight is discarded; dout_valid is not raised for it.

## Timing
- The write path is combinational from registered state:
  - din_ready, wdata_st and buffer_waddr are valid in the same cycle as din_valid.
  - The buffer captures din on that clock edge.
- Buffer read latency is 1 cycle.
- dout_valid and dout_last are registered copies of rdata_st and (rdata_st & raddr_cnt==DEPTH-1), delayed by 1 cycle.
- Stalls: with rd_ready = 0, no read is issued, counters hold and there are no gaps in addressing. Throughput is 1 word/cycle while rd_ready = 1.
- Cycle from FILL exit to READ: READ is entered on the cycle after the last write, so the earliest read follows the last write by 1 cycle.
- layer_done rises 1 cycle after the final rdata_st, in the same cycle as the final dout_valid/dout_last.

## Structure
- Shared package (fc_pkg) holds:
  - The state enum: IDLE, FILL, READ, DONE.
  - Constant ADDR_W = 6.
  - Function ceil_div used to compute DEPTH.
- One natural sub-module: fc_wrap_counter, a parameterised modulo counter with en, a wrap pulse and synchronous clear. It is instantiated three times: bank/word, raddr and pass.
- The one-hot decode and the FSM stay in the top module.

## Test plan
- Defaults, continuous din_valid from layer_start:
  - Feature 17 → wdata_st = 0x0002, waddr = 1.
  - Feature 399 → wdata_st = 0x8000, waddr = 24.
  - din_ready drops the next cycle.
- Defaults, rd_ready held high:
  - Exactly 375 rdata_st cycles with raddr sequence 0..24 repeated 15 times.
  - 15 dout_last pulses.
  - layer_done once, coincident with the last dout_valid.
- rd_ready toggled 1,0,1,0 and din_valid with random gaps: addresses never skip or repeat, and write/read counts are unchanged.
- FEAT_NUM=100, PASS_NUM=2:
  - DEPTH = 7; the last write goes to bank 3, addr 6.
  - Reads run 0..6 twice, 14 in total.
- rst asserted at read 100, with a read issued that cycle: all outputs are 0 next cycle, and no dout_valid follows.
- layer_start pulsed mid-FILL and in the DONE cycle is ignored. A subsequent layer_start in IDLE starts a clean layer from bank 0, addr 0.
